// File: rtl/icache_line_fill.sv
// ----------------------------------------------------------------------------
// icache_line_fill
//
// Refill engine that sits directly below the instruction cache. On a miss it
// accepts one line request, fetches the line as BEATS sequential word reads
// on the instruction memory bus, assembles the words into a line buffer and
// returns the line with a one-cycle ack. An icache kill abandons the fill,
// but a word read already on the bus is always allowed to finish first.
//
// Handshakes:
//   icache side : icache_req_i is held high until icache_ack_o or until the
//                 icache abandons the fill (kill, or dropping the request).
//                 icache_ack_o is a single-cycle pulse; icache_rdata_o is
//                 valid in that cycle and holds until the next fill writes
//                 its first word.
//   bus side    : bus_req_o is the valid. Once raised, bus_req_o and
//                 bus_addr_o stay constant until the cycle bus_ack_i is high
//                 (the ready/complete). bus_rdata_i is only sampled with
//                 bus_ack_i; bus_ack_i with no request outstanding is ignored.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   icache_req_i    line fill request
//   icache_addr_i   miss byte address (line offset bits ignored)
//   icache_kill_i   abandon the current fill
//   icache_rdata_o  assembled line, word k at bits [BUS_WIDTH*k +: BUS_WIDTH]
//   icache_ack_o    one-cycle line-valid pulse
//   bus_req_o       word read request
//   bus_addr_o      word byte address (0 when no request is outstanding)
//   bus_rdata_i     read data, valid with bus_ack_i
//   bus_ack_i       word read complete
//   dbg_state       FSM state for debug/checkers (0 IDLE, 1 FILL, 2 ABORT,
//                   3 DONE)
// ----------------------------------------------------------------------------
module icache_line_fill #(
  parameter int BUS_WIDTH  = 32,
  parameter int BEATS      = 4,
  parameter int LINE_WIDTH = BEATS * BUS_WIDTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icache_req_i,
  input  logic [ADDR_WIDTH-1:0] icache_addr_i,
  input  logic                  icache_kill_i,
  output logic [LINE_WIDTH-1:0] icache_rdata_o,
  output logic                  icache_ack_o,
  output logic                  bus_req_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  input  logic [BUS_WIDTH-1:0]  bus_rdata_i,
  input  logic                  bus_ack_i,
  output logic [1:0]            dbg_state
);

  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_SHIFT = $clog2(BUS_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ABORT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [BEAT_W-1:0]       beat, beat_nxt;
  logic [ADDR_WIDTH-1:0]   base, base_nxt;
  logic [LINE_WIDTH-1:0]   line_q;
  logic                    word_we;
  logic                    abandon;

  // The icache gives up on the fill either by kill or by dropping its request.
  assign abandon = icache_kill_i | ~icache_req_i;

  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat;
    base_nxt     = base;
    word_we      = 1'b0;
    bus_req_o    = 1'b0;
    icache_ack_o = 1'b0;

    case (state)
      IDLE: begin
        if (icache_req_i && !icache_kill_i) begin
          base_nxt  = icache_addr_i & ~OFF_MASK;
          beat_nxt  = '0;
          state_nxt = FILL;
        end
      end

      FILL: begin
        bus_req_o = 1'b1;
        if (abandon) begin
          // A read already acked this cycle is complete, so we can leave the
          // bus at once; otherwise the read must be drained in ABORT.
          state_nxt = bus_ack_i ? IDLE : ABORT;
        end else if (bus_ack_i) begin
          word_we = 1'b1;
          if (beat == LAST_BEAT) begin
            state_nxt = DONE;
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
      end

      ABORT: begin
        // base/beat are frozen here, so the outstanding address is held.
        bus_req_o = 1'b1;
        if (bus_ack_i) begin
          state_nxt = IDLE;
        end
      end

      DONE: begin
        icache_ack_o = ~icache_kill_i;
        state_nxt    = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Beats never cross the line, so a plain add of the word offset is enough.
  assign bus_addr_o = bus_req_o ? (base + (ADDR_WIDTH'(beat) << WORD_SHIFT))
                                : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      beat   <= '0;
      base   <= '0;
      line_q <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      base  <= base_nxt;
      for (int k = 0; k < BEATS; k++) begin
        if (word_we && (beat == BEAT_W'(k))) begin
          line_q[k*BUS_WIDTH +: BUS_WIDTH] <= bus_rdata_i;
        end
      end
    end
  end

  assign icache_rdata_o = line_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_icache_line_fill.sv
// ----------------------------------------------------------------------------
// tb_icache_line_fill
//
// Directed bench for icache_line_fill. A bus responder process models the
// instruction memory (table of hand-chosen words, configurable wait states)
// and checks every acked word address against an expected-address queue. A
// monitor process pops the expected line queue whenever icache_ack_o is
// seen. Stimulus drives at the negative edge, so all sampling happens away
// from the active (positive) edge.
// ----------------------------------------------------------------------------
module tb_icache_line_fill;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ABORT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [127:0] LINE_8000 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_100  = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
  localparam logic [127:0] LINE_40   = 128'h40000004_40000003_40000002_40000001;
  localparam logic [127:0] LINE_80   = 128'h80000004_80000003_80000002_80000001;
  localparam logic [127:0] LINE_MIX  = 128'h40000004_40000003_40000002_80000001;
  localparam logic [127:0] LINE_200  = 128'h20000004_20000003_20000002_20000001;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         icache_req_i;
  logic [31:0]  icache_addr_i;
  logic         icache_kill_i;
  logic [127:0] icache_rdata_o;
  logic         icache_ack_o;
  logic         bus_req_o;
  logic [31:0]  bus_addr_o;
  logic [31:0]  bus_rdata_i;
  logic         bus_ack_i;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  icache_line_fill dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_req_i   (icache_req_i),
    .icache_addr_i  (icache_addr_i),
    .icache_kill_i  (icache_kill_i),
    .icache_rdata_o (icache_rdata_o),
    .icache_ack_o   (icache_ack_o),
    .bus_req_o      (bus_req_o),
    .bus_addr_o     (bus_addr_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ack_i      (bus_ack_i),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q[$];
  logic [31:0]  exp_addr_q[$];
  int checks = 0;
  int passes = 0;
  int bus_waits = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_event(input string name);
    checks++;
    $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0010: mem_word = 32'h1111_1111;
      32'h8000_0014: mem_word = 32'h2222_2222;
      32'h8000_0018: mem_word = 32'h3333_3333;
      32'h8000_001C: mem_word = 32'h4444_4444;
      32'h0000_0100: mem_word = 32'hCAFE_0000;
      32'h0000_0104: mem_word = 32'hCAFE_0001;
      32'h0000_0108: mem_word = 32'hCAFE_0002;
      32'h0000_010C: mem_word = 32'hCAFE_0003;
      32'h0000_0040: mem_word = 32'h4000_0001;
      32'h0000_0044: mem_word = 32'h4000_0002;
      32'h0000_0048: mem_word = 32'h4000_0003;
      32'h0000_004C: mem_word = 32'h4000_0004;
      32'h0000_0080: mem_word = 32'h8000_0001;
      32'h0000_0084: mem_word = 32'h8000_0002;
      32'h0000_0088: mem_word = 32'h8000_0003;
      32'h0000_008C: mem_word = 32'h8000_0004;
      32'h0000_0200: mem_word = 32'h2000_0001;
      32'h0000_0204: mem_word = 32'h2000_0002;
      32'h0000_0208: mem_word = 32'h2000_0003;
      32'h0000_020C: mem_word = 32'h2000_0004;
      default:       mem_word = 32'hDEAD_BEEF;
    endcase
  endfunction

  // ---------------- bus responder ----------------
  initial begin
    int          wcnt;
    logic [31:0] held;
    wcnt        = 0;
    held        = '0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus_ack_i = 1'b0;
      if (!rst_n) begin
        wcnt = 0;
      end else if (bus_req_o) begin
        if (wcnt == 0) held = bus_addr_o;
        else chk("bus_addr_stable", bus_addr_o, held);
        if (wcnt < bus_waits) begin
          wcnt++;
        end else begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = mem_word(bus_addr_o);
          if (exp_addr_q.size() == 0) fail_event("expected_bus_addr_available");
          else chk("bus_addr", bus_addr_o, exp_addr_q.pop_front());
          wcnt = 0;
        end
      end else if (wcnt != 0) begin
        chk("bus_req_held", bus_req_o, 1'b1);
        wcnt = 0;
      end
    end
  end

  // ---------------- line monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (icache_ack_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_ack: actual ack=1 required ack=0 (cycle %0d)", cyc);
        end else begin
          chk("line_data", icache_rdata_o, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_addrs(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_addr(input logic [31:0] a);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_req_o && bus_addr_o == a) return;
    end
    fail_event("wait_bus_addr");
  endtask

  task automatic wait_ack(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (icache_ack_o) begin
        at = cyc;
        return;
      end
    end
    fail_event("wait_icache_ack");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dbg_state == ST_IDLE) return;
    end
    fail_event("wait_idle");
  endtask

  // Full fill; latency counts the request cycle as cycle 1.
  task automatic do_fill(input logic [31:0] addr, input logic [127:0] line, input int exp_lat);
    int t0, t1;
    push_addrs(addr & 32'hFFFF_FFF0, 4);
    exp_q.push_back(line);
    @(negedge clk);
    icache_addr_i = addr;
    icache_req_i  = 1'b1;
    t0 = cyc;
    wait_ack(t1);
    icache_req_i = 1'b0;
    if (t1 >= 0) chk("ack_latency", 128'(t1 - t0 + 1), 128'(exp_lat));
    @(negedge clk);
    chk("ack_one_cycle", icache_ack_o, 1'b0);
    chk("idle_after_done", dbg_state, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    rst_n         = 1'b0;
    icache_req_i  = 1'b0;
    icache_kill_i = 1'b0;
    icache_addr_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", bus_req_o, 1'b0);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    chk("rst_ack", icache_ack_o, 1'b0);
    chk("rst_rdata", icache_rdata_o, 128'h0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;

    // Basic zero-wait fill with an unaligned miss address.
    bus_waits = 0;
    do_fill(32'h8000_0014, LINE_8000, 6);

    // Two wait states before every bus ack.
    bus_waits = 2;
    do_fill(32'h8000_0014, LINE_8000, 14);

    // Kill during beat 2 while its bus read is still pending.
    bus_waits = 2;
    push_addrs(32'h8000_0010, 3);
    @(negedge clk);
    icache_addr_i = 32'h8000_0014;
    icache_req_i  = 1'b1;
    wait_addr(32'h8000_0018);
    icache_kill_i = 1'b1;
    @(negedge clk);
    icache_kill_i = 1'b0;
    icache_req_i  = 1'b0;
    chk("abort_state", dbg_state, ST_ABORT);
    chk("abort_addr_held", bus_addr_o, 32'h8000_0018);
    wait_idle();
    chk("abort_drained", 128'(exp_addr_q.size()), 128'h0);
    bus_waits = 0;
    do_fill(32'h0000_0100, LINE_100, 6);

    // Kill in the same cycle as the beat-1 bus ack.
    bus_waits = 0;
    push_addrs(32'h8000_0010, 2);
    @(negedge clk);
    icache_addr_i = 32'h8000_0010;
    icache_req_i  = 1'b1;
    wait_addr(32'h8000_0014);
    icache_kill_i = 1'b1;
    @(negedge clk);
    chk("kill_ack_bus_req_low", bus_req_o, 1'b0);
    chk("kill_ack_idle", dbg_state, ST_IDLE);
    icache_kill_i = 1'b0;
    icache_req_i  = 1'b0;

    // Back-to-back fills; the second is accepted right after the first ack.
    bus_waits = 0;
    push_addrs(32'h0000_0040, 4);
    push_addrs(32'h0000_0080, 4);
    exp_q.push_back(LINE_40);
    exp_q.push_back(LINE_80);
    @(negedge clk);
    icache_addr_i = 32'h0000_0040;
    icache_req_i  = 1'b1;
    wait_ack(t);
    icache_addr_i = 32'h0000_0080;
    @(negedge clk);
    chk("b2b_idle", dbg_state, ST_IDLE);
    chk("b2b_hold_idle", icache_rdata_o, LINE_40);
    @(negedge clk);
    chk("b2b_accept_req", bus_req_o, 1'b1);
    chk("b2b_accept_addr", bus_addr_o, 32'h0000_0080);
    chk("b2b_hold_beat0", icache_rdata_o, LINE_40);
    @(negedge clk);
    chk("b2b_beat0_written", icache_rdata_o, LINE_MIX);
    wait_ack(t);
    icache_req_i = 1'b0;
    @(negedge clk);

    // Kill during DONE suppresses the ack.
    bus_waits = 0;
    push_addrs(32'h0000_0040, 4);
    @(negedge clk);
    icache_addr_i = 32'h0000_0040;
    icache_req_i  = 1'b1;
    wait_addr(32'h0000_004C);
    @(posedge clk);
    #1;
    icache_kill_i = 1'b1;
    icache_req_i  = 1'b0;
    @(negedge clk);
    chk("done_kill_state", dbg_state, ST_DONE);
    chk("done_kill_no_ack", icache_ack_o, 1'b0);
    @(posedge clk);
    #1;
    icache_kill_i = 1'b0;
    @(negedge clk);
    chk("done_kill_idle", dbg_state, ST_IDLE);

    // Reset in the middle of beat 3.
    bus_waits = 2;
    push_addrs(32'h0000_0040, 3);
    @(negedge clk);
    icache_addr_i = 32'h0000_0040;
    icache_req_i  = 1'b1;
    wait_addr(32'h0000_004C);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_bus_req", bus_req_o, 1'b0);
    chk("midrst_bus_addr", bus_addr_o, 32'h0);
    chk("midrst_ack", icache_ack_o, 1'b0);
    chk("midrst_rdata", icache_rdata_o, 128'h0);
    chk("midrst_state", dbg_state, ST_IDLE);
    rst_n        = 1'b1;
    icache_req_i = 1'b0;
    bus_waits    = 0;
    do_fill(32'h0000_0200, LINE_200, 6);

    // ---------------- final report ----------------
    repeat (3) @(negedge clk);
    chk("lines_all_returned", 128'(exp_q.size()), 128'h0);
    chk("bus_addrs_all_seen", 128'(exp_addr_q.size()), 128'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
